// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: duty sequencer for the PWM block (static level, fade up/down, breathe).
//   Updates duty_cycle only on period_wrap, so no PWM period is ever truncated.
//   Ports: clk, resetn (async, active-low); cfg_valid/cfg_ready handshake with
//   cfg_mode (0 static, 1 up, 2 down, 3 breathe), cfg_lo, cfg_hi, cfg_step;
//   stop; period_wrap from PWM; duty_cycle to PWM; busy, done, cycle_done, cfg_err.
//   Define PWM_FADE_GAMMA_EN to drive duty_cycle through a gamma table (DUTY_W=4 only).
module pwm_fade_ctrl #(
  parameter int DUTY_W = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [DUTY_W-1:0] cfg_lo,
  input  logic [DUTY_W-1:0] cfg_hi,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              stop,
  input  logic              period_wrap,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              done,
  output logic              cycle_done,
  output logic              cfg_err
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RAMP_UP = 2'd2, RAMP_DOWN = 2'd3;
  logic [1:0] state, state_n, mode;
  logic [DUTY_W-1:0] lv, lv_n, lo, hi, duty_n;
  logic [STEP_W-1:0] cnt, cnt_n, step_m;
  logic done_n, cyc_n, err_n, step_ev, accept;
  assign cfg_ready = state == IDLE;
  assign busy = !cfg_ready;
  assign accept = cfg_ready && cfg_valid && cfg_lo <= cfg_hi;
  assign step_ev = period_wrap && cnt == step_m;
  always_comb begin
    state_n = state;
    lv_n = lv;
    cnt_n = cnt;
    done_n = 1'b0;
    cyc_n = 1'b0;
    err_n = 1'b0;
    if (state == IDLE) begin
      err_n = cfg_valid && cfg_lo > cfg_hi;
      state_n = accept ? LOAD : IDLE;
    end else if (stop) begin
      state_n = IDLE;
    end else if (period_wrap && state == LOAD) begin
      cnt_n = '0;
      lv_n = mode == 2'd2 ? hi : lo;
      done_n = mode == 2'd0 || lo == hi;
      state_n = done_n ? IDLE : (mode == 2'd2 ? RAMP_DOWN : RAMP_UP);
    end else if (period_wrap) begin
      cnt_n = step_ev ? '0 : cnt + 1'b1;
      if (step_ev && state == RAMP_UP) begin
        lv_n = lv + 1'b1;
        if (lv_n == hi) begin
          done_n = mode == 2'd1;
          state_n = mode == 2'd3 ? RAMP_DOWN : IDLE;
        end
      end else if (step_ev) begin
        lv_n = lv - 1'b1;
        if (lv_n == lo) begin
          done_n = mode == 2'd2;
          cyc_n = mode == 2'd3;
          state_n = mode == 2'd3 ? RAMP_UP : IDLE;
        end
      end
    end
  end
`ifdef PWM_FADE_GAMMA_EN
  localparam logic [DUTY_W-1:0] GAMMA [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
  assign duty_n = GAMMA[lv_n];
`else
  assign duty_n = lv_n;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      lv <= '0;
      cnt <= '0;
      mode <= '0;
      lo <= '0;
      hi <= '0;
      step_m <= '0;
      duty_cycle <= '0;
      done <= 1'b0;
      cycle_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      lv <= lv_n;
      cnt <= cnt_n;
      duty_cycle <= duty_n;
      done <= done_n;
      cycle_done <= cyc_n;
      cfg_err <= err_n;
      if (accept) begin
        mode <= cfg_mode;
        lo <= cfg_lo;
        hi <= cfg_hi;
        step_m <= cfg_step == '0 ? '0 : cfg_step - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: scoreboard bench for pwm_fade_ctrl; expected duty/pulses queued per wrap.
module tb_pwm_fade_ctrl;
  logic clk = 0, resetn = 0, cfg_valid = 0, stop = 0, period_wrap = 0;
  logic [1:0] cfg_mode = 0;
  logic [3:0] cfg_lo = 0, cfg_hi = 0, duty_cycle;
  logic [7:0] cfg_step = 0;
  logic cfg_ready, busy, done, cycle_done, cfg_err;
  int checks = 0, errors = 0;
  typedef struct {int duty; bit dn; bit cyc; bit bsy;} exp_t;
  exp_t sb[$];
  pwm_fade_ctrl dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_step(cfg_step),
    .stop(stop), .period_wrap(period_wrap), .duty_cycle(duty_cycle), .busy(busy),
    .done(done), .cycle_done(cycle_done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  function automatic int g(int v);
    int t [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
`ifdef PWM_FADE_GAMMA_EN
    return t[v];
`else
    return v + 0 * t[0];
`endif
  endfunction
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void push(int d, bit dn, bit c, bit b);
    sb.push_back('{d, dn, c, b});
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wrap();
    exp_t e;
    period_wrap = 1;
    tick();
    period_wrap = 0;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("duty", duty_cycle, e.duty);
      chk("done", done, e.dn);
      chk("cycle_done", cycle_done, e.cyc);
      chk("busy", busy, e.bsy);
    end
  endtask
  task automatic cfg(int m, int l, int h, int s);
    cfg_valid = 1;
    cfg_mode = 2'(m);
    cfg_lo = 4'(l);
    cfg_hi = 4'(h);
    cfg_step = 8'(s);
    tick();
    cfg_valid = 0;
  endtask
  task automatic drain();
    while (sb.size() > 0) wrap();
  endtask
  initial begin
    int seq [8] = '{2, 3, 2, 1, 2, 3, 2, 1};
    tick();
    tick();
    chk("rst_duty", duty_cycle, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done", done, 0);
    resetn = 1;
    tick();
    period_wrap = 1;
    tick();
    period_wrap = 0;
    chk("idle_wrap_duty", duty_cycle, 0);
    chk("idle_wrap_busy", busy, 0);
    cfg(0, 9, 9, 3);
    chk("load_busy", busy, 1);
    chk("load_ready", cfg_ready, 0);
    push(g(9), 1, 0, 0);
    drain();
    chk("static_ready", cfg_ready, 1);
    tick();
    chk("static_done_once", done, 0);
    cfg(1, 2, 5, 2);
    push(g(2), 0, 0, 1);
    for (int lv = 3; lv <= 5; lv++)
      for (int k = 0; k < 2; k++) push(g(k == 1 ? lv : lv - 1), k == 1 && lv == 5, 0, !(k == 1 && lv == 5));
    drain();
    tick();
    chk("fade_done_once", done, 0);
    cfg(3, 1, 3, 0);
    push(g(1), 0, 0, 1);
    foreach (seq[i]) push(g(seq[i]), 0, seq[i] == 1, 1);
    push(g(2), 0, 0, 1);
    drain();
    stop = 1;
    tick();
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_duty", duty_cycle, g(2));
    chk("stop_done", done, 0);
    period_wrap = 1;
    tick();
    period_wrap = 0;
    chk("post_stop_duty", duty_cycle, g(2));
    cfg(1, 7, 4, 1);
    chk("err_pulse", cfg_err, 1);
    chk("err_busy", busy, 0);
    chk("err_duty", duty_cycle, g(2));
    tick();
    chk("err_once", cfg_err, 0);
    cfg(2, 0, 15, 1);
    push(g(15), 0, 0, 1);
    for (int lv = 14; lv >= 10; lv--) push(g(lv), 0, 0, 1);
    drain();
    stop = 1;
    period_wrap = 1;
    tick();
    stop = 0;
    period_wrap = 0;
    chk("stopstep_duty", duty_cycle, g(10));
    chk("stopstep_busy", busy, 0);
    chk("stopstep_done", done, 0);
    cfg(2, 0, 15, 1);
    push(g(15), 0, 0, 1);
    push(g(14), 0, 0, 1);
    push(g(13), 0, 0, 1);
    drain();
    resetn = 0;
    #1;
    chk("async_rst_duty", duty_cycle, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", cfg_ready, 1);
    tick();
    resetn = 1;
    cfg(1, 0, 15, 1);
    push(g(0), 0, 0, 1);
    for (int lv = 1; lv <= 15; lv++) push(g(lv), lv == 15, 0, lv != 15);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
